// File: rtl/alu_mul_seq_if.sv
// rtl/alu_mul_seq_if.sv - shared-ALU request/grant and operand bus for the multiplier sequencer
interface alu_mul_seq_if;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_res;
    logic        alu_zero;

    modport master (
        output alu_req, alu_a, alu_b, alu_aluc,
        input  alu_gnt, alu_res, alu_zero
    );

    modport slave (
        input  alu_req, alu_a, alu_b, alu_aluc,
        output alu_gnt, alu_res, alu_zero
    );
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add 32-bit multiplier that borrows the shared single-cycle ALU
module alu_mul_seq (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   op_a,
    input  logic [31:0]   op_b,
    output logic          busy,
    output logic          done,
    output logic [31:0]   product,
    alu_mul_seq_if.master alu
);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ALU drive depends only on registered state so the owner can arbitrate without a comb loop through alu_gnt
    always_comb begin
        state_nxt    = state;
        alu.alu_req  = 1'b0;
        alu.alu_a    = 32'd0;
        alu.alu_b    = 32'd0;
        alu.alu_aluc = ALU_ADD;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (op_b == 32'd0) ? S_DONE : S_ADD;
                end
            end
            S_ADD: begin
                alu.alu_req = 1'b1;
                alu.alu_a   = acc;
                alu.alu_b   = mcand;
                if (alu.alu_gnt) begin
                    state_nxt = S_SHL;
                end
            end
            S_SHL: begin
                alu.alu_req  = 1'b1;
                alu.alu_a    = 32'd1;
                alu.alu_b    = mcand;
                alu.alu_aluc = ALU_SLL;
                if (alu.alu_gnt) begin
                    state_nxt = S_SHR;
                end
            end
            S_SHR: begin
                alu.alu_req  = 1'b1;
                alu.alu_a    = 32'd1;
                alu.alu_b    = mplier;
                alu.alu_aluc = ALU_SRL;
                if (alu.alu_gnt) begin
                    state_nxt = alu.alu_zero ? S_DONE : S_ADD;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc     <= 32'd0;
            mcand   <= 32'd0;
            mplier  <= 32'd0;
            product <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= 32'd0;
                        mcand  <= op_a;
                        mplier <= op_b;
                    end
                end
                S_ADD: begin
                    if (alu.alu_gnt && mplier[0]) begin
                        acc <= alu.alu_res;
                    end
                end
                S_SHL: begin
                    if (alu.alu_gnt) begin
                        mcand <= alu.alu_res;
                    end
                end
                S_SHR: begin
                    if (alu.alu_gnt) begin
                        mplier <= alu.alu_res;
                    end
                end
                S_DONE: begin
                    product <= acc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - randomized self-checking bench for alu_mul_seq against an arithmetic reference
module tb_alu_mul_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [31:0] last_product;
    int          n_cmp = 0;
    int          n_bad = 0;

    alu_mul_seq_if alu_bus ();

    alu_mul_seq dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .alu     (alu_bus.master)
    );

    always #5 clock = ~clock;

    // Shared single-cycle ALU as seen by the sequencer
    always_comb begin
        case (alu_bus.alu_aluc)
            4'b0000: alu_bus.alu_res = alu_bus.alu_a + alu_bus.alu_b;
            4'b0011: alu_bus.alu_res = alu_bus.alu_b << alu_bus.alu_a[4:0];
            4'b0111: alu_bus.alu_res = alu_bus.alu_b >> alu_bus.alu_a[4:0];
            default: alu_bus.alu_res = 32'd0;
        endcase
    end
    assign alu_bus.alu_zero = (alu_bus.alu_res == 32'd0);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int top_bits(input logic [31:0] b);
        int k = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) k = i + 1;
        end
        return k;
    endfunction

    // mode: 0 full grant, 1 random grant, 2 grant withheld in cycles 2..5
    // pulse_cyc: cycle after accept in which a stray start (9 x 9) is pulsed, 0 for none
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode, input int pulse_cyc);
        int          k;
        int          s;
        int          n;
        int          i;
        logic        g;
        logic [31:0] mask;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [3:0]  exp_c;
        k     = top_bits(b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        s     = 0;
        n     = 1;
        // 3k granted ALU steps, each grant advances one step of the schedule
        while (s < 3 * k) begin
            i    = s / 3;
            mask = (32'd1 << i) - 32'd1;
            case (s % 3)
                0: begin exp_c = 4'b0000; exp_a = a * (b & mask); exp_b = a << i; end
                1: begin exp_c = 4'b0011; exp_a = 32'd1;          exp_b = a << i; end
                default: begin exp_c = 4'b0111; exp_a = 32'd1;    exp_b = b >> i; end
            endcase
            case (mode)
                0: g = 1'b1;
                1: g = ($urandom_range(0, 3) != 0) || (n > 300);
                default: g = !(n >= 2 && n <= 5);
            endcase
            alu_bus.alu_gnt = g;
            if (n == pulse_cyc) begin
                start = 1'b1;
                op_a  = 32'd9;
                op_b  = 32'd9;
            end else begin
                start = 1'b0;
            end
            check_val("busy_run", busy, 1'b1);
            check_val("done_early", done, 1'b0);
            check_val("alu_req_run", alu_bus.alu_req, 1'b1);
            check_val("alu_aluc", alu_bus.alu_aluc, exp_c);
            check_val("alu_a", alu_bus.alu_a, exp_a);
            check_val("alu_b", alu_bus.alu_b, exp_b);
            check_val("product_held", product, last_product);
            if (g) s++;
            n++;
            @(posedge clock);
            #1;
        end
        start = (n == pulse_cyc);
        check_val("done_pulse", done, 1'b1);
        check_val("busy_done", busy, 1'b1);
        check_val("alu_req_done", alu_bus.alu_req, 1'b0);
        check_val("alu_a_done", alu_bus.alu_a, 32'd0);
        check_val("alu_b_done", alu_bus.alu_b, 32'd0);
        check_val("alu_aluc_done", alu_bus.alu_aluc, 32'd0);
        check_val("product_pre", product, last_product);
        @(posedge clock);
        #1;
        start        = 1'b0;
        last_product = a * b;
        check_val("product", product, last_product);
        check_val("done_after", done, 1'b0);
        check_val("busy_after", busy, 1'b0);
        check_val("alu_req_idle", alu_bus.alu_req, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset           = 1'b1;
        start           = 1'b0;
        op_a            = 32'd0;
        op_b            = 32'd0;
        alu_bus.alu_gnt = 1'b0;
        last_product    = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_product", product, 32'd0);
        check_val("rst_alu_req", alu_bus.alu_req, 1'b0);
        check_val("rst_alu_a", alu_bus.alu_a, 32'd0);
        check_val("rst_alu_b", alu_bus.alu_b, 32'd0);
        check_val("rst_alu_aluc", alu_bus.alu_aluc, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("idle_busy", busy, 1'b0);

        run_op(32'd6, 32'd7, 0, 0);
        run_op(32'h1234, 32'd0, 0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(32'd5, 32'd3, 2, 0);
        run_op(32'd2, 32'd5, 0, 3);
        for (int t = 0; t < 20; t++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, 1, (t % 4 == 0) ? 2 : 0);
        end
        run_op(32'd3, 32'd3, 1, 0);

        // reset while the sequencer sits in its first SHR step
        alu_bus.alu_gnt = 1'b1;
        op_a  = 32'h77;
        op_b  = 32'h55;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("pre_rst_shr", alu_bus.alu_aluc, 4'b0111);
        reset = 1'b1;
        #1;
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_done", done, 1'b0);
        check_val("arst_alu_req", alu_bus.alu_req, 1'b0);
        check_val("arst_product", product, 32'd0);
        check_val("arst_alu_b", alu_bus.alu_b, 32'd0);
        #2;
        reset        = 1'b0;
        last_product = 32'd0;
        @(posedge clock);
        #1;
        check_val("post_rst_done", done, 1'b0);
        check_val("post_rst_busy", busy, 1'b0);
        run_op(32'd4, 32'd4, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned multiplier sequencer that computes a 32-bit product by driving the shared single-cycle ALU with a shift-add schedule (ADD, SLL, SRL per multiplier bit). It sits beside the CPU datapath and requests the ALU through a request/grant pair, so the datapath owner can lend it idle ALU cycles. It gives the IO and CPU side a MUL facility without a hardware multiplier array.

## Interface
Parameters: none (data width fixed at 32).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request a multiply; accepted only in IDLE
- op_a  in  32  multiplicand, sampled on accept
- op_b  in  32  multiplier, sampled on accept
- busy  out  1  high from the cycle after accept until DONE is left
- done  out  1  one-cycle pulse in DONE
- product  out  32  low 32 bits of op_a*op_b; valid from done, held until next accept
- alu_req  out  1  high in ADD/SHL/SHR states
- alu_gnt  in  1  ALU granted to this block this cycle
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_aluc  out  4  ALU opcode
- alu_res  in  32  ALU result, combinational from alu_a/alu_b/alu_aluc
- alu_zero  in  1  ALU result-is-zero flag

## Operation
- ALU opcodes used: ADD 4'b0000, SLL 4'b0011 (res = b << a), SRL 4'b0111 (res = b >> a).
- Internal registers: acc, mcand, mplier (32 bits each), state, product.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE: on start=1, load acc=0, mcand=op_a, mplier=op_b. If op_b==0, go to DONE, else go to ADD. start=0 stays in IDLE.
- ADD: alu_a=acc, alu_b=mcand, aluc=ADD. If granted: acc<=alu_res when mplier[0]=1 (unchanged otherwise); go to SHL.
- SHL: alu_a=1, alu_b=mcand, aluc=SLL. If granted: mcand<=alu_res; go to SHR.
- SHR: alu_a=1, alu_b=mplier, aluc=SRL. If granted: mplier<=alu_res; go to DONE if alu_zero=1, else go to ADD.
- DONE: product<=acc (the registered value is visible the following cycle), done=1 for this cycle only, then go to IDLE.
- Grant stall: in ADD/SHL/SHR with alu_gnt=0, hold state and all registers; alu_req stays high; ALU outputs keep their values.
- IDLE/DONE: alu_req=0, alu_a=0, alu_b=0, alu_aluc=ADD.
- start while busy or in DONE: ignored, with no queuing.
- Arithmetic is modulo 2^32. Overflow is discarded silently; no flag.
- Termination needs no counter: mplier reaches zero after at most 32 SRLs.

## Timing
- Reset values: busy=0, done=0, product=0, alu_req=0, alu_a=0, alu_b=0, alu_aluc=0; state=IDLE, acc/mcand/mplier=0.
- Reset mid-operation: return to IDLE immediately, with no done pulse. product clears to 0.
- Latency (full grant): with k = bit index of highest set bit of op_b, plus 1, done is high in cycle 3k+1 after the accept edge.
- op_b=0: done is high in cycle 1.
- Each cycle with alu_gnt=0 during ADD/SHL/SHR adds one cycle.
- The product register updates on the edge that leaves DONE. Consumers sample product on the cycle after done, or later.
- A new start is accepted at the earliest in the cycle after DONE (IDLE), giving back-to-back throughput of 3k+2 cycles.
- alu_a/alu_b/alu_aluc/alu_req are decoded combinationally from the registered state and registers only; they never depend on alu_gnt.

## Test plan
- op_a=6, op_b=7, alu_gnt=1 -> done high 10 cycles after accept; product=42 on the following cycle; busy high cycles 1-10.
- op_a=0x1234, op_b=0 -> done in cycle 1; product=0; alu_req never asserted.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done in cycle 97; product=0x00000001.
- op_a=5, op_b=3, alu_gnt low for 4 cycles during the first SHL -> done in cycle 11; product=15; registers frozen and alu_req=1 throughout the stall.
- Pulse start with op_a=9, op_b=9 in cycle 3 of an op_a=2, op_b=5 run -> second request ignored; product=10; busy falls after DONE.
- Assert reset during an SHR state -> busy/done/alu_req/product are 0 immediately. A subsequent start with op_a=4, op_b=4 yields product=16.
